fmps_write_link: RTL

- Transmit end of the FMPS cell link. On each fast-acquisition strobe, it emits one two-word AXI-Stream packet carrying the local FMPS word.
- The packet format is the one the cell-link receivers decode:
  - header word: magic, enable flag, index
  - data word: invalid flags plus payload, with TLAST
- Sits in the auroraClk domain between the local FMPS source and the Aurora TX user interface.
- Provides a completion strobe and packet/overrun counters for link statistics.

---
 rtl/fmps_write_link_if.sv | 10 +
 rtl/fmps_write_link.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fmps_write_link_if.sv
// AXI-Stream TX channel between the FMPS link transmitter and the Aurora TX user interface.
interface fmps_write_link_if;
    logic        TVALID;
    logic        TLAST;
    logic [31:0] TDATA;
    logic        TREADY;

    modport master (output TVALID, output TLAST, output TDATA, input TREADY);
    modport slave  (input TVALID, input TLAST, input TDATA, output TREADY);
endinterface

// File: rtl/fmps_write_link.sv
// FMPS cell-link transmitter: one two-word AXI-Stream packet (header, data+TLAST)
// per accepted fast-acquisition strobe, with completion strobe and statistics counters.
// Optional error injection ports are enabled by defining FMPS_WRITE_LINK_ERROR_INJECT_EN.
module fmps_write_link #(
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   auroraClk,
    input  logic                   auroraResetN,
    input  logic                   FAstrobe,
    input  logic                   txEnable,
    input  logic                   fmpsEnabled,
    input  logic [INDEX_WIDTH-1:0] fmpsIndex,
    input  logic                   fmpsValid,
    input  logic [29:0]            fmpsData,
`ifdef FMPS_WRITE_LINK_ERROR_INJECT_EN
    input  logic                   injectBadPacket,
    input  logic                   injectBadHeader,
`endif
    fmps_write_link_if.master      axis,
    output logic                   statusStrobe,
    output logic [COUNT_WIDTH-1:0] txCount,
    output logic [COUNT_WIDTH-1:0] overrunCount,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA
    } state_t;

    state_t      state;
    state_t      stateNext;

    // Header fields are captured straight into TDATA at the strobe, so only
    // the data-word fields need their own latches.
    logic        latValid;
    logic [29:0] latData;
    logic        badBit;
    logic [15:0] magic;

    logic        validNext;
    logic        lastNext;
    logic [31:0] dataNext;
    logic [31:0] headerWord;
    logic [31:0] dataWord;
    logic        capture;
    logic        sent;
    logic        overrunHit;

`ifdef FMPS_WRITE_LINK_ERROR_INJECT_EN
    logic        latBadPacket;

    // Capture the bad-packet request with the other fields on an accepted strobe.
    always_ff @(posedge auroraClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            latBadPacket <= 1'b0;
        end else if (capture) begin
            latBadPacket <= injectBadPacket;
        end
    end

    assign badBit = latBadPacket;
    assign magic  = injectBadHeader ? 16'hB6CE : 16'hB6CF;
`else
    assign badBit = 1'b0;
    assign magic  = 16'hB6CF;
`endif

    assign overrunHit = FAstrobe && txEnable && (state != S_IDLE);
    assign busy       = (state != S_IDLE);
    assign dataWord   = {~latValid, badBit, latData};

    // Header word assembled from the live inputs at the moment the strobe is accepted.
    always_comb begin
        headerWord                      = '0;
        headerWord[31:16]               = magic;
        headerWord[15]                  = fmpsEnabled;
        headerWord[10 +: INDEX_WIDTH]   = fmpsIndex;
    end

    // Next-state and next-output decode; outputs hold unless a transition occurs.
    always_comb begin
        stateNext = state;
        validNext = axis.TVALID;
        lastNext  = axis.TLAST;
        dataNext  = axis.TDATA;
        capture   = 1'b0;
        sent      = 1'b0;
        case (state)
            S_IDLE: begin
                if (FAstrobe && txEnable) begin
                    capture   = 1'b1;
                    stateNext = S_HEADER;
                    validNext = 1'b1;
                    lastNext  = 1'b0;
                    dataNext  = headerWord;
                end
            end
            S_HEADER: begin
                if (axis.TREADY) begin
                    stateNext = S_DATA;
                    lastNext  = 1'b1;
                    dataNext  = dataWord;
                end
            end
            S_DATA: begin
                if (axis.TREADY) begin
                    sent      = 1'b1;
                    stateNext = S_IDLE;
                    validNext = 1'b0;
                    lastNext  = 1'b0;
                    dataNext  = '0;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // State, registered bus outputs and latched data-word fields.
    always_ff @(posedge auroraClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            state       <= S_IDLE;
            axis.TVALID <= 1'b0;
            axis.TLAST  <= 1'b0;
            axis.TDATA  <= '0;
            latValid    <= 1'b0;
            latData     <= '0;
        end else begin
            state       <= stateNext;
            axis.TVALID <= validNext;
            axis.TLAST  <= lastNext;
            axis.TDATA  <= dataNext;
            if (capture) begin
                latValid <= fmpsValid;
                latData  <= fmpsData;
            end
        end
    end

    // Completion strobe and link statistics: txCount wraps, overrunCount saturates.
    always_ff @(posedge auroraClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            statusStrobe <= 1'b0;
            txCount      <= '0;
            overrunCount <= '0;
        end else begin
            statusStrobe <= sent;
            if (sent) begin
                txCount <= txCount + 1'b1;
            end
            if (overrunHit && (overrunCount != '1)) begin
                overrunCount <= overrunCount + 1'b1;
            end
        end
    end

endmodule
